// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the dmem arbiter: FSM state codes and owner codes.
package dmem_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE     = 2'd0;
  localparam arb_state_t ST_CORE_ACC = 2'd1;
  localparam arb_state_t ST_HOST_ACC = 2'd2;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  function automatic arb_state_t owner_state(input logic owner);
    return (owner == OWN_HOST) ? ST_HOST_ACC : ST_CORE_ACC;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the side
// opposite the last grant.
module rr_arbiter_2
  import dmem_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  output logic o_gnt_vld,
  output logic o_gnt_owner
);

  assign o_gnt_vld = i_req0 | i_req1;

  always_comb begin
    o_gnt_owner = OWN_CORE;
    if (i_req0 && i_req1) o_gnt_owner = ~i_last_grant;
    else if (i_req1)      o_gnt_owner = OWN_HOST;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the core load/store path and a host port,
// sequencing each access over MEM_LAT cycles and stalling the core meanwhile.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic [3:0]        core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              host_req,
  input  logic [3:0]        host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  contention
);

  localparam int               LAT_W    = $clog2(MEM_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

  arb_state_t        r_state;
  logic [LAT_W-1:0]  r_cnt;
  logic              r_last;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_we;
  logic [CNT_W-1:0]  r_contention;

  logic w_gnt_vld;
  logic w_gnt_owner;
  logic w_busy;
  logic w_last_cyc;
  logic w_core_done;
  logic w_host_done;
  logic w_both_wait;

  rr_arbiter_2 u_rr (
    .i_req0       (core_req),
    .i_req1       (host_req),
    .i_last_grant (r_last),
    .o_gnt_vld    (w_gnt_vld),
    .o_gnt_owner  (w_gnt_owner)
  );

  assign w_busy      = (r_state == ST_CORE_ACC) || (r_state == ST_HOST_ACC);
  assign w_last_cyc  = (r_cnt == LAT_ONE);
  assign w_core_done = (r_state == ST_CORE_ACC) && w_last_cyc;
  assign w_host_done = (r_state == ST_HOST_ACC) && w_last_cyc;
  assign w_both_wait = core_req && host_req && !w_core_done && !w_host_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_last  <= OWN_HOST;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_vld) begin
            r_state <= owner_state(w_gnt_owner);
            r_cnt   <= LAT_INIT;
            r_last  <= w_gnt_owner;
            if (w_gnt_owner == OWN_HOST) begin
              r_addr  <= host_addr;
              r_wdata <= host_wdata;
              r_we    <= host_we;
            end else begin
              r_addr  <= core_addr;
              r_wdata <= core_wdata;
              r_we    <= core_we;
            end
          end
        end
        ST_CORE_ACC, ST_HOST_ACC: begin
          r_cnt <= r_cnt - LAT_ONE;
          if (w_last_cyc) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Saturating count of cycles where both sides are stuck waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    r_contention <= '0;
    else if (w_both_wait && (r_contention != '1)) r_contention <= r_contention + 1'b1;
  end

  // Write enables only in the first access cycle so a store lands exactly once.
  assign mem_addr   = w_busy ? r_addr  : '0;
  assign mem_wdata  = w_busy ? r_wdata : '0;
  assign mem_we     = (w_busy && (r_cnt == LAT_INIT)) ? r_we : 4'h0;

  assign core_stall = core_req && !w_core_done;
  assign core_rdata = w_core_done ? mem_rdata : '0;
  assign host_ack   = w_host_done;
  assign host_rdata = w_host_done ? mem_rdata : '0;
  assign contention = r_contention;

endmodule
